// File: rtl/rtc_bus_sequencer.sv
// Multiplexed-bus master for the RTC: refreshes a register window into a shadow bank and serves writes.
// Each transaction is 2*(T_SETUP+T_PULSE+T_HOLD) clocks; a write requester holds wr_req until wr_ack.
module rtc_bus_sequencer #(
    parameter int         NUM_REGS  = 6,
    parameter logic [7:0] BASE_ADDR = 8'h21,
    parameter int         T_SETUP   = 2,
    parameter int         T_PULSE   = 4,
    parameter int         T_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  refresh_en,
    input  logic                  wr_req,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_ack,
    output logic                  cs_n,
    output logic                  rd_n,
    output logic                  wr_n,
    output logic                  a_d,
    output logic [7:0]            ad_out,
    output logic                  ad_oe,
    input  logic [7:0]            ad_in,
    output logic [8*NUM_REGS-1:0] shadow,
    output logic                  refresh_done,
    output logic                  busy
);
    localparam int            PW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int            CW        = 16;
    localparam logic [CW-1:0] SETUP_LD  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(T_HOLD - 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic                     is_wr_q, is_wr_d;
    logic [7:0]               addr_q, addr_d;
    logic [7:0]               data_q, data_d;
    logic                     wr_ack_q, wr_ack_d;
    logic                     refresh_done_q, refresh_done_d;
    logic [NUM_REGS-1:0][7:0] shadow_q, shadow_d;
    logic                     cnt_last;
    logic [7:0]               win_off;
    logic                     in_addr_ph;
    logic                     in_data_ph;

    assign cnt_last = (cnt_q == '0);
    // Offset relative to the window base; wraps mod 256 so windows crossing 8'hFF work.
    assign win_off  = addr_q - BASE_ADDR;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        is_wr_d        = is_wr_q;
        addr_d         = addr_q;
        data_d         = data_q;
        wr_ack_d       = 1'b0;
        refresh_done_d = 1'b0;
        shadow_d       = shadow_q;

        if (state_q != IDLE && !cnt_last) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                // wr_req is still high in the ack cycle; that request was already served.
                if (wr_req && !wr_ack_q) begin
                    is_wr_d = 1'b1;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    state_d = A_SET;
                    cnt_d   = SETUP_LD;
                end else if (refresh_en) begin
                    is_wr_d = 1'b0;
                    addr_d  = BASE_ADDR + 8'(ptr_q);
                    state_d = A_SET;
                    cnt_d   = SETUP_LD;
                end
            end
            A_SET: if (cnt_last) begin state_d = A_STB; cnt_d = PULSE_LD; end
            A_STB: if (cnt_last) begin state_d = A_HLD; cnt_d = HOLD_LD;  end
            A_HLD: if (cnt_last) begin state_d = D_SET; cnt_d = SETUP_LD; end
            D_SET: if (cnt_last) begin state_d = D_STB; cnt_d = PULSE_LD; end
            D_STB: begin
                if (cnt_last) begin
                    state_d = D_HLD;
                    cnt_d   = HOLD_LD;
                    if (!is_wr_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (ptr_q == PW'(i)) shadow_d[i] = ad_in;
                        end
                    end
                end
            end
            D_HLD: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (is_wr_q) begin
                        wr_ack_d = 1'b1;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (win_off == 8'(i)) shadow_d[i] = data_q;
                        end
                    end else if (ptr_q == LAST_SLOT) begin
                        ptr_d          = '0;
                        refresh_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ptr_q          <= '0;
            is_wr_q        <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            wr_ack_q       <= 1'b0;
            refresh_done_q <= 1'b0;
            shadow_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            is_wr_q        <= is_wr_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            wr_ack_q       <= wr_ack_d;
            refresh_done_q <= refresh_done_d;
            shadow_q       <= shadow_d;
        end
    end

    // Bus pins decode straight from state so an async reset releases the bus at once.
    assign in_addr_ph   = (state_q == A_SET) || (state_q == A_STB) || (state_q == A_HLD);
    assign in_data_ph   = (state_q == D_SET) || (state_q == D_STB) || (state_q == D_HLD);
    assign cs_n         = (state_q == IDLE);
    assign a_d          = in_data_ph;
    assign wr_n         = !((state_q == A_STB) || ((state_q == D_STB) && is_wr_q));
    assign rd_n         = !((state_q == D_STB) && !is_wr_q);
    assign ad_oe        = in_addr_ph || (in_data_ph && is_wr_q);
    assign ad_out       = in_addr_ph ? addr_q : ((in_data_ph && is_wr_q) ? data_q : 8'h00);
    assign busy         = (state_q != IDLE);
    assign wr_ack       = wr_ack_q;
    assign refresh_done = refresh_done_q;
    assign shadow       = shadow_q;

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Parametrised master for the RTC chip's multiplexed address/data bus.
- Continuously refreshes a contiguous window of RTC registers into a shadow bank read by the VGA display path.
- Serves single-byte write requests from the control FSM, with priority over refresh.
- Replaces hard-coded per-register bus sequencing; register count, base address and strobe timing are parameters.

Parameters:
- NUM_REGS, 6: registers in the refresh window (1..32).
- BASE_ADDR, 8'h21: RTC address of shadow slot 0; slot i maps to BASE_ADDR+i.
- T_SETUP, 2: clocks a_d/ad are stable before a strobe (>=1).
- T_PULSE, 4: clocks a strobe is held low (>=1).
- T_HOLD, 2: clocks a_d/ad are held after a strobe rises (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- refresh_en  in  1  1 = sweep the window continuously.
- wr_req  in  1  write request, level, held until wr_ack.
- wr_addr  in  8  RTC write address.
- wr_data  in  8  RTC write data.
- wr_ack  out  1  one-cycle pulse when the write data phase completes.
- cs_n  out  1  chip select, active low.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- a_d  out  1  0 = address phase, 1 = data phase.
- ad_out  out  8  bus drive value.
- ad_oe  out  1  tristate enable; the top level builds the inout from ad_out/ad_oe/ad_in.
- ad_in  in  8  bus sample.
- shadow  out  8*NUM_REGS  slot i at bits [8i+7:8i].
- refresh_done  out  1  one-cycle pulse after the last slot of a sweep is read.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - cs_n = rd_n = wr_n = 1; a_d = 0; ad_oe = 0; ad_out = 0.
  - wr_ack = refresh_done = busy = 0; all shadow slots = 0; slot pointer = 0; state = IDLE.
- States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD. One down-counter loads T_SETUP, T_PULSE or T_HOLD on state entry.
- IDLE:
  - wr_req=1 starts a write transaction.
  - Otherwise refresh_en=1 starts a read of slot ptr.
  - Otherwise stay in IDLE.
  - The decision is made here only; a request arriving mid-transaction waits.
- A_SET: cs_n=0, a_d=0, ad_oe=1, ad_out=address (wr_addr latched, or BASE_ADDR+ptr).
- A_STB: wr_n=0 (address latch). A_HLD: wr_n=1, address still driven.
- D_SET: a_d=1.
  - Write: ad_out = latched wr_data, ad_oe=1.
  - Read: ad_oe=0.
- D_STB:
  - Write: wr_n=0.
  - Read: rd_n=0; ad_in is sampled into shadow[ptr] on the last D_STB cycle.
- D_HLD: strobes high, cs_n still 0. On exit: cs_n=1, ad_oe=0, a_d=0, return to IDLE.
- Timing:
  - Every transaction lasts exactly 2*(T_SETUP+T_PULSE+T_HOLD) clocks.
  - At least one IDLE clock with cs_n=1 separates transactions.
  - Defaults give 16 busy clocks.
- rd_n and wr_n are never low together. ad_oe is never 1 while rd_n=0.
- Write completion:
  - wr_ack pulses in the first IDLE cycle after the write.
  - If wr_addr is in [BASE_ADDR, BASE_ADDR+NUM_REGS-1], that shadow slot takes wr_data in the same cycle.
  - Out-of-window writes leave the shadow untouched.
  - Refresh ptr is unaffected by writes.
- Refresh pointer:
  - Increments after each read and wraps NUM_REGS-1 -> 0.
  - refresh_done pulses in the same cycle as the wrap.
- refresh_en dropping mid-read does not abort the read; the sequencer idles after it.
- An async reset mid-transaction releases the bus immediately (all strobes high, ad_oe=0). The in-flight write is lost with no wr_ack.
- Address arithmetic is 8-bit and wraps modulo 256.

Test Plan:
- Reset: hold reset=0 with refresh_en=1 -> cs_n=rd_n=wr_n=1, ad_oe=0, shadow=0, busy=0. Release -> cs_n falls 1 clock later with ad_out=8'h21, a_d=0.
- Refresh sweep: bus model returns addr^8'hFF, refresh_en=1 -> after 6 reads shadow slot0=8'hDE ... slot5=8'hD9. refresh_done pulses once per 102 clocks (6x17).
- Strobe timing: check cs_n low for exactly 16 clocks per transaction. Check wr_n low 4 clocks in the address phase, and rd_n low 4 clocks in the read data phase, with 2 clocks setup/hold around each edge.
- Write priority: wr_req=1, wr_addr=8'h23, wr_data=8'h45 raised mid-read -> the read completes, then the write runs next, driving 8'h45 in the data phase. wr_ack pulses once and shadow slot2=8'h45. The refresh resumes at the following slot.
- Out-of-window write: wr_addr=8'h41, wr_data=8'h10 -> bus write performed, wr_ack=1, shadow unchanged.
- Reset mid-write: assert reset during D_STB -> wr_n=1, cs_n=1, ad_oe=0 the same cycle. No wr_ack after release.
